// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: each channel emits a one-cycle tick
// every (period+1) enabled clocks, periodic or one-shot, with a global pause.
//
// state    | meaning
// ST_IDLE  | channel stopped, counter cleared, no ticks
// ST_RUN   | channel counting enabled cycles towards its active period
module tick_gen_multi #(
    parameter int NUM_CH         = 4,
    parameter int CNT_WDTH       = 30,
    parameter int DEFAULT_PERIOD = 100,
    parameter int AUTO_START     = 0,
    parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                mclk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                cfg_we_i,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [CNT_WDTH-1:0] cfg_period_i,
    input  logic                cfg_oneshot_i,
    input  logic [NUM_CH-1:0]   start_i,
    input  logic [NUM_CH-1:0]   stop_i,
    output logic [NUM_CH-1:0]   tick_o,
    output logic [NUM_CH-1:0]   busy_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [CNT_WDTH-1:0] DEF_PERIOD = CNT_WDTH'(DEFAULT_PERIOD);
    localparam state_t RST_STATE = (AUTO_START != 0) ? ST_RUN : ST_IDLE;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t              state_q;
        logic [CNT_WDTH-1:0] cnt_q;
        logic [CNT_WDTH-1:0] act_period_q;
        logic [CNT_WDTH-1:0] period_q;
        logic [CNT_WDTH-1:0] period_d;
        logic                oneshot_q;
        logic                oneshot_d;
        logic                tick_q;
        logic                wr_sel;

        // Out-of-range channel indices never match any g, so they are dropped here.
        assign wr_sel = cfg_we_i && (cfg_ch_i == CH_W'(g));

        always_comb begin
            period_d  = period_q;
            oneshot_d = oneshot_q;
            if (wr_sel) begin
                period_d  = cfg_period_i;
                oneshot_d = cfg_oneshot_i;
            end
        end

        always_ff @(posedge mclk_i) begin
            if (rst_i) begin
                state_q      <= RST_STATE;
                cnt_q        <= '0;
                act_period_q <= DEF_PERIOD;
                period_q     <= DEF_PERIOD;
                oneshot_q    <= 1'b0;
                tick_q       <= 1'b0;
            end else begin
                period_q  <= period_d;
                oneshot_q <= oneshot_d;
                tick_q    <= 1'b0;
                if (stop_i[g]) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end else if (start_i[g]) begin
                    // Write-first: a config write on this same edge is already in period_d.
                    state_q      <= ST_RUN;
                    cnt_q        <= '0;
                    act_period_q <= period_d;
                end else if (state_q == ST_RUN) begin
                    if (en_i) begin
                        if (cnt_q == act_period_q) begin
                            cnt_q        <= '0;
                            tick_q       <= 1'b1;
                            act_period_q <= period_d;
                            if (oneshot_q) begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end

        assign tick_o[g] = tick_q;
        assign busy_o[g] = (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi: a 4-channel manual-start instance and a
// 3-channel auto-start instance, checked against hand-computed tick/busy vectors.
module tb_tick_gen_multi;

    localparam int W = 30;

    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic          rst_a, en_a, we_a, os_a;
    logic [1:0]    ch_a;
    logic [W-1:0]  per_a;
    logic [3:0]    start_a, stop_a, tick_a, busy_a;

    logic          rst_b, en_b, we_b, os_b;
    logic [1:0]    ch_b;
    logic [W-1:0]  per_b;
    logic [2:0]    start_b, stop_b, tick_b, busy_b;

    int n_chk  = 0;
    int n_fail = 0;

    tick_gen_multi #(.NUM_CH(4), .CNT_WDTH(W), .DEFAULT_PERIOD(100), .AUTO_START(0)) u_dut_a (
        .mclk_i(mclk), .rst_i(rst_a), .en_i(en_a), .cfg_we_i(we_a), .cfg_ch_i(ch_a),
        .cfg_period_i(per_a), .cfg_oneshot_i(os_a), .start_i(start_a), .stop_i(stop_a),
        .tick_o(tick_a), .busy_o(busy_a)
    );

    tick_gen_multi #(.NUM_CH(3), .CNT_WDTH(W), .DEFAULT_PERIOD(100), .AUTO_START(1)) u_dut_b (
        .mclk_i(mclk), .rst_i(rst_b), .en_i(en_b), .cfg_we_i(we_b), .cfg_ch_i(ch_b),
        .cfg_period_i(per_b), .cfg_oneshot_i(os_b), .start_i(start_b), .stop_i(stop_b),
        .tick_o(tick_b), .busy_o(busy_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic cfg_a(input logic [1:0] ch, input logic [W-1:0] per, input logic os);
        we_a = 1'b1; ch_a = ch; per_a = per; os_a = os;
    endtask

    task automatic clr_a();
        we_a = 1'b0; os_a = 1'b0; start_a = '0; stop_a = '0;
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b1; we_a = 1'b0; os_a = 1'b0; ch_a = '0; per_a = '0;
        start_a = '0; stop_a = '0;
        rst_b = 1'b1; en_b = 1'b1; we_b = 1'b0; os_b = 1'b0; ch_b = '0; per_b = '0;
        start_b = '0; stop_b = '0;
        step();
        step();
        check("a_rst_tick", tick_a, 4'b0000);
        check("a_rst_busy", busy_a, 4'b0000);
        check("b_rst_tick", tick_b, 3'b000);
        check("b_rst_busy", busy_b, 3'b111);
        rst_a = 1'b0;

        // ch0 P=3 periodic, config written on the start edge
        cfg_a(2'd0, 3, 1'b0); start_a = 4'b0001;
        step(); clr_a();
        check("t1_start_busy", busy_a, 4'b0001);
        check("t1_start_tick", tick_a, 4'b0000);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("t1_tick", tick_a, (k % 4 == 0) ? 4'b0001 : 4'b0000);
            check("t1_busy", busy_a, 4'b0001);
        end

        // period change while running: old spacing once, then every 2 cycles
        step();
        check("t3_tick13", tick_a, 4'b0000);
        cfg_a(2'd0, 1, 1'b0);
        step(); clr_a();
        check("t3_tick14", tick_a, 4'b0000);
        for (int k = 15; k <= 21; k++) begin
            step();
            check("t3_tick", tick_a, (k == 16 || k == 18 || k == 20) ? 4'b0001 : 4'b0000);
        end
        start_a = 4'b0001; stop_a = 4'b0001;
        step(); clr_a();
        check("t3_stopwin_busy", busy_a, 4'b0000);
        check("t3_stopwin_tick", tick_a, 4'b0000);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("t3_idle_tick", tick_a, 4'b0000);
            check("t3_idle_busy", busy_a, 4'b0000);
        end

        // ch1 one-shot P=5
        cfg_a(2'd1, 5, 1'b1); start_a = 4'b0010;
        step(); clr_a();
        check("t2_start_busy", busy_a, 4'b0010);
        for (int k = 1; k <= 56; k++) begin
            step();
            check("t2_tick", tick_a, (k == 6) ? 4'b0010 : 4'b0000);
            check("t2_busy", busy_a, (k < 6) ? 4'b0010 : 4'b0000);
        end

        // ch2 P=4 with a 7-cycle pause at cnt=2
        cfg_a(2'd2, 4, 1'b0); start_a = 4'b0100;
        step(); clr_a();
        for (int k = 1; k <= 2; k++) begin
            step();
            check("t4_pre_tick", tick_a, 4'b0000);
        end
        en_a = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("t4_hold_tick", tick_a, 4'b0000);
            check("t4_hold_busy", busy_a, 4'b0100);
        end
        en_a = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("t4_resume_tick", tick_a, (k == 3) ? 4'b0100 : 4'b0000);
        end
        stop_a = 4'b0100;
        step(); clr_a();
        check("t4_stop_busy", busy_a, 4'b0000);

        // ch3 P=0: tick on every enabled cycle
        cfg_a(2'd3, 0, 1'b0); start_a = 4'b1000;
        step(); clr_a();
        check("t6_p0_start_tick", tick_a, 4'b0000);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t6_p0_tick", tick_a, 4'b1000);
        end
        en_a = 1'b0;
        step();
        check("t6_p0_paused", tick_a, 4'b0000);
        en_a = 1'b1;
        step();
        check("t6_p0_resumed", tick_a, 4'b1000);
        stop_a = 4'b1000;
        step(); clr_a();

        // auto-start instance: default period 100 -> ticks every 101 cycles
        rst_b = 1'b0;
        for (int k = 1; k <= 202; k++) begin
            step();
            check("t5_auto_tick", tick_b, (k % 101 == 0) ? 3'b111 : 3'b000);
        end
        check("t5_auto_busy", busy_b, 3'b111);
        for (int k = 1; k <= 57; k++) begin
            step();
        end
        rst_b = 1'b1;
        step();
        check("t5_rst_tick", tick_b, 3'b000);
        check("t5_rst_busy", busy_b, 3'b111);
        rst_b = 1'b0;
        for (int k = 1; k <= 101; k++) begin
            step();
            check("t5_restart_tick", tick_b, (k == 101) ? 3'b111 : 3'b000);
        end

        // write to nonexistent channel 3 must not change any period
        we_b = 1'b1; ch_b = 2'd3; per_b = 0;
        step();
        we_b = 1'b0; start_b = 3'b111;
        step();
        start_b = '0;
        check("t6_oob_start_tick", tick_b, 3'b000);
        for (int k = 1; k <= 101; k++) begin
            step();
            check("t6_oob_tick", tick_b, (k == 101) ? 3'b111 : 3'b000);
        end

        // write-first on the auto-start instance: ch1 gets P=0 on its restart edge
        we_b = 1'b1; ch_b = 2'd1; per_b = 0; start_b = 3'b010;
        step();
        we_b = 1'b0; start_b = '0;
        check("b_wf_start", tick_b[1], 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("b_wf_tick", tick_b[1], 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
